// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the transmit arbiter and the UART
// byte sender. The arbiter takes the master side; the slave side is the
// requester/sender environment.
interface uart_tx_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        ack;
   logic                    tx_start;
   logic [DATA_W-1:0]       tx_data;
   logic                    tx_busy;
   logic                    active;
   logic [2:0]              cur_id;
   logic                    err_timeout;

   modport master (
      input  req, req_data, tx_busy,
      output ack, tx_start, tx_data, active, cur_id, err_timeout
   );

   modport slave (
      output req, req_data, tx_busy,
      input  ack, tx_start, tx_data, active, cur_id, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte sender among N_REQ requesters.
// A grant latches the winner's byte, pulses ack/tx_start for one cycle, then
// follows the sender's busy flag until the frame completes. A sender that
// never raises busy within BUSY_TIMEOUT cycles is abandoned with err_timeout.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   uart_tx_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   localparam logic [7:0]       TO_LAST  = 8'(BUSY_TIMEOUT - 1);
   localparam logic [2:0]       LAST_RST = 3'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   state_t            state_q;
   logic [2:0]        last_q;
   logic [2:0]        cur_id_q;
   logic [7:0]        cnt_q;
   logic [N_REQ-1:0]  ack_q;
   logic              tx_start_q;
   logic              active_q;
   logic              err_q;
   logic [DATA_W-1:0] tx_data_q;

   logic              win_vld_d;
   logic [2:0]        win_id_d;
   logic [DATA_W-1:0] win_data_d;
   int                best_d;

   // Round-robin search: the set req bit at the smallest distance above last wins.
   always_comb begin
      win_vld_d  = 1'b0;
      win_id_d   = '0;
      win_data_d = '0;
      best_d     = N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
         if (bus.req[i] && (((i + N_REQ - 1 - int'(last_q)) % N_REQ) < best_d)) begin
            best_d    = (i + N_REQ - 1 - int'(last_q)) % N_REQ;
            win_vld_d = 1'b1;
            win_id_d  = 3'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (win_id_d == 3'(i)) begin
            win_data_d = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Arbitration FSM with all outputs registered so ack/tx_start/err are glitch-free.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         last_q     <= LAST_RST;
         cur_id_q   <= '0;
         cnt_q      <= '0;
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A busy sender (e.g. a frame surviving a reset) blocks any new grant.
               if (win_vld_d && !bus.tx_busy) begin
                  state_q    <= S_START;
                  tx_data_q  <= win_data_d;
                  cur_id_q   <= win_id_d;
                  last_q     <= win_id_d;
                  ack_q      <= ONE_HOT0 << win_id_d;
                  tx_start_q <= 1'b1;
                  active_q   <= 1'b1;
               end
            end
            S_START: begin
               cnt_q   <= '0;
               state_q <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state_q <= S_WAIT_DONE;
               end else if (cnt_q == TO_LAST) begin
                  // last_q keeps the failed requester so the pointer still moves on.
                  err_q    <= 1'b1;
                  state_q  <= S_IDLE;
                  active_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  state_q  <= S_IDLE;
                  active_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack         = ack_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.active      = active_q;
   assign bus.cur_id      = cur_id_q;
   assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of single transactions plus
// hand-written sequences for round-robin, timeout, busy gate, reset mid-frame
// and an early request drop. A small sender model raises tx_busy after start.
module tb_uart_tx_arbiter;
   localparam int N_REQ        = 4;
   localparam int DATA_W       = 8;
   localparam int BUSY_TIMEOUT = 16;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

   uart_tx_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .bus(bus.master)
   );

   always #5 CLK = ~CLK;

   int   n_tests   = 0;
   int   n_fail    = 0;
   bit   model_en  = 1'b1;
   logic model_busy = 1'b0;
   logic man_busy   = 1'b0;
   int   busy_dly  = 2;
   int   busy_len  = 20;
   int   m_wait    = 0;
   int   m_left    = 0;
   int   viol_busy = 0;
   int   viol_pair = 0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [3:0]  exp_ack;
      logic [2:0]  exp_id;
      logic [7:0]  exp_data;
   } vec_t;

   typedef struct {
      logic [3:0] ack;
      logic [2:0] id;
      logic [7:0] data;
   } txn_t;

   vec_t vecs[8];
   txn_t log_q[$];
   txn_t mon_t;
   int   rr_exp[5];

   assign bus.tx_busy = model_en ? model_busy : man_busy;

   // Sender model: busy rises busy_dly cycles after tx_start, stays busy_len cycles.
   always @(posedge CLK) begin
      #1;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) model_busy = 1'b0;
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            model_busy = 1'b1;
            m_left     = busy_len;
         end
      end else if (model_en && bus.tx_start) begin
         m_wait = busy_dly;
      end
   end

   // Transaction monitor and protocol watch.
   always @(negedge CLK) begin
      if (bus.ack != '0) begin
         mon_t.ack  = bus.ack;
         mon_t.id   = bus.cur_id;
         mon_t.data = bus.tx_data;
         log_q.push_back(mon_t);
      end
      if (bus.tx_start && bus.tx_busy) viol_busy++;
      if (bus.tx_start != (bus.ack != '0)) viol_pair++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((bus.active !== 1'b0 || bus.tx_busy !== 1'b0) && n < 300) begin
         @(negedge CLK);
         n++;
      end
      check({name, "_idle_wait"}, 32'(n < 300), 1);
   endtask

   task automatic wait_busy(input logic lvl, input string name);
      int n = 0;
      while (bus.tx_busy !== lvl && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check({name, "_busy_wait"}, 32'(n < 100), 1);
   endtask

   task automatic wait_ack(input string name);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (bus.ack == '0 && n < 100);
      check({name, "_ack_wait"}, 32'(n < 100), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      vecs[0] = '{4'b0010, 32'h0000_A500, 4'b0010, 3'd1, 8'hA5};
      vecs[1] = '{4'b1000, 32'h3C00_0000, 4'b1000, 3'd3, 8'h3C};
      vecs[2] = '{4'b0001, 32'h0000_005A, 4'b0001, 3'd0, 8'h5A};
      vecs[3] = '{4'b0110, 32'h0077_8800, 4'b0010, 3'd1, 8'h88};
      vecs[4] = '{4'b0110, 32'h0077_8800, 4'b0100, 3'd2, 8'h77};
      vecs[5] = '{4'b1001, 32'hC300_0011, 4'b1000, 3'd3, 8'hC3};
      vecs[6] = '{4'b1001, 32'hC300_0011, 4'b0001, 3'd0, 8'h11};
      vecs[7] = '{4'b1000, 32'hE100_0000, 4'b1000, 3'd3, 8'hE1};
      rr_exp  = '{0, 1, 2, 3, 0};

      bus.req      = '0;
      bus.req_data = '0;
      RST_N        = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_ack",      bus.ack, 0);
      check("rst_tx_start", bus.tx_start, 0);
      check("rst_tx_data",  bus.tx_data, 0);
      check("rst_active",   bus.active, 0);
      check("rst_cur_id",   bus.cur_id, 0);
      check("rst_err",      bus.err_timeout, 0);
      RST_N = 1'b1;
      @(negedge CLK);

      // Single-transaction table.
      for (int v = 0; v < 8; v++) begin
         wait_idle($sformatf("vec%0d", v));
         bus.req      = vecs[v].req;
         bus.req_data = vecs[v].data;
         @(negedge CLK);
         check($sformatf("vec%0d_ack", v),      bus.ack, 32'(vecs[v].exp_ack));
         check($sformatf("vec%0d_tx_start", v), bus.tx_start, 1);
         check($sformatf("vec%0d_cur_id", v),   bus.cur_id, 32'(vecs[v].exp_id));
         check($sformatf("vec%0d_tx_data", v),  bus.tx_data, 32'(vecs[v].exp_data));
         check($sformatf("vec%0d_active", v),   bus.active, 1);
         bus.req = '0;
         @(negedge CLK);
         check($sformatf("vec%0d_ack_pulse", v),   bus.ack, 0);
         check($sformatf("vec%0d_start_pulse", v), bus.tx_start, 0);
         wait_busy(1'b1, $sformatf("vec%0d_rise", v));
         wait_busy(1'b0, $sformatf("vec%0d_fall", v));
         check($sformatf("vec%0d_active_at_fall", v), bus.active, 1);
         check($sformatf("vec%0d_data_stable", v),    bus.tx_data, 32'(vecs[v].exp_data));
         @(negedge CLK);
         check($sformatf("vec%0d_active_after", v),   bus.active, 0);
      end

      // Round-robin with all four requesting continuously.
      wait_idle("rr");
      log_q.delete();
      busy_len     = 10;
      bus.req      = 4'hF;
      bus.req_data = 32'h4433_2211;
      n = 0;
      while (log_q.size() < 5 && n < 400) begin
         @(negedge CLK);
         n++;
      end
      bus.req = '0;
      wait_idle("rr_end");
      check("rr_count", log_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rr%0d_id", i),   log_q[i].id, rr_exp[i]);
         check($sformatf("rr%0d_ack", i),  log_q[i].ack, 32'(4'b0001 << rr_exp[i]));
         check($sformatf("rr%0d_data", i), log_q[i].data, 32'(8'h11 * (rr_exp[i] + 1)));
      end
      busy_len = 20;

      // Timeout with a dead sender.
      model_en     = 1'b0;
      man_busy     = 1'b0;
      bus.req      = 4'h1;
      bus.req_data = 32'h0000_00C4;
      @(negedge CLK);
      check("to_ack", bus.ack, 4'h1);
      bus.req = '0;
      n = 0;
      while (bus.err_timeout !== 1'b1 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check("to_latency", n, BUSY_TIMEOUT + 1);
      check("to_idle", bus.active, 0);
      @(negedge CLK);
      check("to_pulse", bus.err_timeout, 0);
      bus.req = 4'h1;
      @(negedge CLK);
      check("to_regrant_ack", bus.ack, 4'h1);
      check("to_regrant_id",  bus.cur_id, 0);
      bus.req = '0;
      n = 0;
      while (bus.err_timeout !== 1'b1 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check("to_second", 32'(n < 100), 1);
      @(negedge CLK);

      // Busy gate after reset.
      RST_N    = 1'b0;
      man_busy = 1'b1;
      @(negedge CLK);
      RST_N        = 1'b1;
      bus.req      = 4'h4;
      bus.req_data = 32'h009B_0000;
      seen = 0;
      repeat (6) begin
         @(negedge CLK);
         if (bus.ack != '0 || bus.tx_start) seen++;
      end
      check("gate_hold", seen, 0);
      man_busy = 1'b0;
      model_en = 1'b1;
      @(negedge CLK);
      check("gate_ack",  bus.ack, 4'h4);
      check("gate_id",   bus.cur_id, 2);
      check("gate_data", bus.tx_data, 8'h9B);
      bus.req = '0;
      wait_idle("gate");

      // Reset during WAIT_DONE.
      bus.req      = 4'h8;
      bus.req_data = 32'h5E00_0000;
      wait_ack("mid");
      check("mid_ack", bus.ack, 4'h8);
      bus.req = '0;
      wait_busy(1'b1, "mid");
      @(negedge CLK);
      @(negedge CLK);
      check("mid_active", bus.active, 1);
      RST_N = 1'b0;
      #1;
      check("mid_rst_outputs",
            32'({bus.ack, bus.tx_start, bus.tx_data, bus.active, bus.cur_id, bus.err_timeout}), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check("mid_rel_tx_data", bus.tx_data, 0);
      check("mid_rel_cur_id",  bus.cur_id, 0);
      bus.req      = 4'b1001;
      bus.req_data = 32'h7700_00A1;
      wait_ack("mid_prio");
      check("mid_prio_ack",  bus.ack, 4'h1);
      check("mid_prio_data", bus.tx_data, 8'hA1);
      bus.req = 4'b1000;
      wait_ack("mid_next");
      check("mid_next_ack",  bus.ack, 4'h8);
      check("mid_next_data", bus.tx_data, 8'h77);
      bus.req = '0;
      wait_idle("mid");

      // Early request drop during WAIT_DONE.
      log_q.delete();
      bus.req      = 4'h1;
      bus.req_data = 32'h0066_00D2;
      wait_ack("drop");
      bus.req = '0;
      wait_busy(1'b1, "drop");
      @(negedge CLK);
      @(negedge CLK);
      bus.req = 4'h4;
      @(negedge CLK);
      bus.req = '0;
      wait_idle("drop");
      repeat (5) @(negedge CLK);
      check("drop_count", log_q.size(), 1);
      check("drop_id",    log_q[0].id, 0);

      check("no_start_while_busy", viol_busy, 0);
      check("ack_start_paired",    viol_pair, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte sender among N_REQ independent requesters, e.g. a button-driven message counter, an echo path from the receiver, and a status reporter.
- Selects requesters round-robin, latches the winner's byte, issues a one-cycle start to the sender, then tracks the sender's busy flag until the frame completes.
- Detects a sender that never acknowledges a start and recovers from it.
- Sits between the requesters and the sender, in the top-level clock domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, payload width per requester.
- BUSY_TIMEOUT, 16, max CLK cycles to wait for tx_busy to rise after tx_start (1..255).

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester level request; held until the matching ack.
- req_data  input  N_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]; stable while req[i]=1.
- ack  output  N_REQ  one-hot one-cycle pulse when a requester's byte is latched.
- tx_start  output  1  one-cycle start pulse to the sender.
- tx_data  output  DATA_W  latched byte; stable from tx_start until the return to IDLE.
- tx_busy  input  1  sender busy, synchronous to CLK (the integrator synchronises it).
- active  output  1  high in every state except IDLE.
- cur_id  output  3  index of the current or last granted requester.
- err_timeout  output  1  one-cycle pulse when the busy timeout expires.

Behaviour:
- Reset (async assert; release takes effect on the next CLK edge):
  - state=IDLE; ack=0, tx_start=0, tx_data=0, active=0, cur_id=0, err_timeout=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority first.
  - Timeout counter=0.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Grant only when some req bit is 1 AND tx_busy=0.
  - If tx_busy is high (for example after a reset mid-frame), wait for it to drop.
  - Winner = first set req bit searching upward from last+1, wrapping modulo N_REQ.
  - On the grant edge: tx_data<=winner's byte, cur_id<=winner, last<=winner, next state START.
- START (exactly one cycle):
  - ack[cur_id]=1 and tx_start=1 in this cycle only.
  - Timeout counter cleared; next state WAIT_BUSY.
  - Latency: req sampled in IDLE cycle k gives ack and tx_start in cycle k+1.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise the counter increments. If the counter equals BUSY_TIMEOUT-1 while tx_busy=0, pulse err_timeout for one cycle and go to IDLE.
  - last stays at the failed requester, so the pointer still advances and a dead sender cannot starve others.
- WAIT_DONE:
  - tx_busy=0: go to IDLE. The earliest next grant is the following cycle.
  - No timeout in this state.
- Requester rules:
  - A requester must drop req the cycle after its ack.
  - If req is still high, it is treated as a new request, but only wins again when no other requester is pending.
  - A req that drops before being granted generates no transaction.
  - req changes outside IDLE are ignored until the return to IDLE.
- Simultaneous events:
  - Multiple req bits in the same cycle: only the round-robin winner is served.
  - tx_busy already high in START: that is legal; WAIT_BUSY exits on its first cycle.
- Outputs:
  - active = (state != IDLE).
  - ack, tx_start and err_timeout are registered and glitch-free.
- Back-to-back throughput: minimum 4 cycles plus the sender busy time per byte.
- Reset mid-operation:
  - All outputs return to their reset values immediately.
  - A frame in flight in the sender is not aborted. The IDLE tx_busy gate prevents a new start until it finishes.

Test Plan:
1. Single request: after reset, req=4'b0010 with req_data[15:8]=8'hA5, tx_busy rises 2 cycles after tx_start and falls 20 cycles later.
   Required: ack=4'b0010 and tx_start=1 one cycle after req is sampled; tx_data=8'hA5; cur_id=1; active high until the cycle after tx_busy falls.
2. Round-robin fairness: req=4'b1111 held continuously with the sender model busy 10 cycles per byte.
   Required: grant order 0,1,2,3,0; exactly one ack bit per transaction; no tx_start while tx_busy=1.
3. Timeout: tx_busy tied low, req=4'b0001.
   Required: err_timeout pulses exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry (16 with default); then IDLE; the next request from requester 0 is granted again.
4. Busy gate after reset: tx_busy=1 at reset release, req=4'b0100.
   Required: no ack or tx_start until the cycle after tx_busy falls; then ack=4'b0100.
5. Reset mid-frame: assert RST_N=0 during WAIT_DONE.
   Required: all outputs 0 asynchronously; after release, tx_data=0, cur_id=0, and requester 0 has priority over requester 3 when both request.
6. Early request drop: req[2] pulses for one cycle while the arbiter is in WAIT_DONE.
   Required: no ack[2] and no transaction issued for requester 2.
